// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath: sequences instruction phases
// and drives datapath enables, mux selects and the ALU operation code.
module multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] state,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;
  logic       w_pcwrite, w_branch, w_irwrite, w_regwrite, w_memwrite;
  logic       w_iord, w_memtoreg, w_regdst, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 3'b010;
    case (funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    w_next = S_MEMWB;
      S_EXECUTE:  w_next = w_funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEXEC: w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_memwrite   = 1'b0;
    w_iord       = 1'b0;
    w_memtoreg   = 1'b0;
    w_regdst     = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = 3'b010;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
      end
      S_DECODE: w_alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: w_iord = 1'b1;
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca    = 1'b1;
        w_alucontrol = w_funct_alu;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca    = 1'b1;
        w_alucontrol = 3'b110;
        w_pcsrc      = 2'b01;
        w_branch     = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Every output is held at zero while reset is asserted, independent of the clock.
  assign state      = reset_n ? r_state : 4'd0;
  assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
  assign irwrite    = reset_n & w_irwrite;
  assign regwrite   = reset_n & w_regwrite;
  assign memwrite   = reset_n & w_memwrite;
  assign iord       = reset_n & w_iord;
  assign memtoreg   = reset_n & w_memtoreg;
  assign regdst     = reset_n & w_regdst;
  assign alusrca    = reset_n & w_alusrca;
  assign alusrcb    = reset_n ? w_alusrcb : 2'b00;
  assign pcsrc      = reset_n ? w_pcsrc : 2'b00;
  assign alucontrol = reset_n ? w_alucontrol : 3'b000;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction state-path model feeds
// expected per-cycle outputs to a monitor that compares at the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic [3:0] state;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .state(state), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, rw, mw, iord, m2r, rdst, asa;
    logic [1:0] asb, psrc;
    logic [2:0] alu;
    logic       pcw, br;
  } rec_t;

  rec_t q[$];
  int   path[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  function automatic rec_t zero_rec();
    rec_t r;
    r = '0;
    return r;
  endfunction

  function automatic rec_t exp_rec(input int s, input logic [5:0] f);
    rec_t r;
    r     = '0;
    r.st  = s[3:0];
    r.alu = 3'b010;
    case (s)
      0:  begin r.irw = 1; r.pcw = 1; r.asb = 2'b01; end
      1:  r.asb = 2'b11;
      2, 9: begin r.asa = 1; r.asb = 2'b10; end
      3:  r.iord = 1;
      4:  begin r.rw = 1; r.m2r = 1; end
      5:  begin r.iord = 1; r.mw = 1; end
      6: begin
        r.asa = 1;
        if (f == 6'b100010) r.alu = 3'b110;
        else if (f == 6'b100100) r.alu = 3'b000;
        else if (f == 6'b100101) r.alu = 3'b001;
        else if (f == 6'b101010) r.alu = 3'b111;
      end
      7:  begin r.rw = 1; r.rdst = 1; end
      8:  begin r.asa = 1; r.alu = 3'b110; r.psrc = 2'b01; r.br = 1; end
      10: r.rw = 1;
      11: begin r.psrc = 2'b10; r.pcw = 1; end
      default: ;
    endcase
    return r;
  endfunction

  // State path of one instruction, from FETCH up to (not including) the next FETCH.
  task automatic plan(input logic [5:0] o, input logic [5:0] f);
    bit fok;
    fok = f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (o)
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000000: begin path.push_back(6); if (fok) path.push_back(7); end
      6'b000100: path.push_back(8);
      6'b001000: begin path.push_back(9); path.push_back(10); end
      6'b000010: path.push_back(11);
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, expv);
    end
  endtask

  task automatic hold_reset_cycle();
    @(posedge clk); #1;
    reset_n = 1'b0;
    path.delete();
    q.push_back(zero_rec());
    @(negedge clk); #1;
    zero = ~zero;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit rst_in_memwr);
    int  s;
    bit  first;
    bit  did_rst;
    first   = 1'b1;
    did_rst = 1'b0;
    plan(o, f);
    while (path.size() > 0) begin
      @(posedge clk); #1;
      reset_n = 1'b1;
      if (first) begin op = o; funct = f; first = 1'b0; end
      zero = 1'($urandom);
      s = path.pop_front();
      q.push_back(exp_rec(s, f));
      @(negedge clk); #1;
      zero = ~zero;
      if (rst_in_memwr && s == 5) begin
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_memwrite", 32'(memwrite), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_outputs",
              32'({pcen, irwrite, regwrite, iord, alusrcb, pcsrc, alucontrol}), 32'd0);
        path.delete();
        did_rst = 1'b1;
      end
    end
    if (did_rst) begin
      hold_reset_cycle();
      hold_reset_cycle();
    end
  endtask

  // Monitor: pops one expected record per cycle and compares outputs against it.
  initial begin
    rec_t       r;
    logic [17:0] got, expv;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        r    = q.pop_front();
        got  = {state, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol};
        expv = {r.st, r.irw, r.rw, r.mw, r.iord, r.m2r, r.rdst, r.asa, r.asb, r.psrc, r.alu};
        check("outputs", 32'(got), 32'(expv));
        check("pcen", 32'(pcen), 32'(r.pcw | (r.br & zero)));
        #2;
        check("pcen_after_zero_toggle", 32'(pcen), 32'(r.pcw | (r.br & zero)));
      end
    end
  end

  logic [5:0] d_op[14] = '{6'b100011, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                           6'b000000, 6'b000000, 6'b000100, 6'b000100, 6'b101011,
                           6'b001000, 6'b000010, 6'b111111, 6'b101011};
  logic [5:0] d_fn[14] = '{6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b000111, 6'b000000, 6'b000000, 6'b000000,
                           6'b000000, 6'b000000, 6'b000000, 6'b000000};
  logic [5:0] ops[6]   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] fns[5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] o, f;
    reset_n = 1'b0;
    op      = 6'd0;
    funct   = 6'd0;
    zero    = 1'b0;
    repeat (3) hold_reset_cycle();

    for (int i = 0; i < 14; i++)
      run_instr(d_op[i], d_fn[i], (i == 9));

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        o = 6'($urandom);
        while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})
          o = 6'($urandom);
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else                           f = fns[$urandom_range(0, 4)];
      run_instr(o, f, ($urandom_range(0, 15) == 0));
    end

    @(negedge clk); #3;
    done = 1'b1;
    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style controller for the multicycle MIPS datapath. It sits directly upstream of the ALU. It sequences fetch/decode/execute/memory/writeback states and drives every datapath enable and mux select, including the 3-bit alucontrol consumed by the ALU. It takes the ALU zero flag back to resolve beq.

Parameters:
none. Opcode, funct and state encodings are fixed constants listed below.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  instruction[31:26] from instruction register
funct  in  6  instruction[5:0] from instruction register
zero  in  1  ALU zero flag
state  out  4  current state (debug/verification)
pcen  out  1  PC write enable = pcwrite | (branch & zero)
irwrite  out  1  instruction register load
regwrite  out  1  register file write
memwrite  out  1  data memory write
iord  out  1  0: address = PC, 1: address = ALUOut
memtoreg  out  1  1: write-back data from memory
regdst  out  1  1: destination is rd, 0: rt
alusrca  out  1  0: PC, 1: register A
alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alucontrol  out  3  ALU operation code

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. The controller never emits codes 100 or 101.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- State register:
  - Async clear to FETCH when reset_n falls.
  - Leaves FETCH on the first rising edge after reset_n rises.
- Output forcing during reset: while reset_n = 0, all outputs are forced to 0 (pcen, irwrite, regwrite, memwrite, all selects, alucontrol = 000). state reads 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEXEC (addi), JUMP (j).
  - DECODE -> FETCH on an unknown opcode (instruction is a no-op).
  - MEMADR -> MEMRD (lw) or MEMWR (sw). MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH.
  - EXECUTE -> ALUWB -> FETCH. If funct is not in {add, sub, and, or, slt}, EXECUTE -> FETCH and ALUWB is skipped (no register write).
  - BRANCH -> FETCH. ADDIEXEC -> ADDIWB -> FETCH. JUMP -> FETCH.
  - States 12–15 -> FETCH; all outputs in these states use the defaults.
- Default outputs: every enable 0, every select 0, alucontrol 010.
- Per-state outputs (signals not listed take the default):
  - FETCH: irwrite 1, pcwrite 1, iord 0, alusrca 0, alusrcb 01, ADD, pcsrc 00.
  - DECODE: alusrca 0, alusrcb 11, ADD (branch target into ALUOut).
  - MEMADR and ADDIEXEC: alusrca 1, alusrcb 10, ADD.
  - MEMRD: iord 1.
  - MEMWB: regwrite 1, memtoreg 1, regdst 0.
  - MEMWR: iord 1, memwrite 1.
  - EXECUTE: alusrca 1, alusrcb 00, alucontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, otherwise ADD.
  - ALUWB: regwrite 1, regdst 1, memtoreg 0.
  - BRANCH: alusrca 1, alusrcb 00, SUB, pcsrc 01, internal branch 1.
  - ADDIWB: regwrite 1, regdst 0.
  - JUMP: pcsrc 10, pcwrite 1.
- pcen is combinational from state and zero; it is the only Mealy output. All other outputs depend on state only.
- op is sampled in DECODE and MEMADR; funct is sampled in EXECUTE. The instruction register holds both stable after FETCH, so the controller does not register them.
- Latency from FETCH entry to the next FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown op 2, unknown funct 3 cycles.
- Reset mid-instruction: state returns to FETCH immediately, outputs are forced to 0 at once, and no partial write occurs after reset_n falls.

Test Plan:
- Reset: reset_n low mid-MEMWR (memwrite 1) -> memwrite drops to 0 asynchronously. After release: state 0, irwrite = 1, pcen = 1, alusrcb 01, alucontrol 010.
- lw (op 100011) -> state sequence 0,1,2,3,4,0. In state 4: regwrite 1, memtoreg 1. In state 3: iord 1.
- R-type, one run per funct (100000, 100010, 100100, 100101, 101010):
  - alucontrol in EXECUTE is 010, 110, 000, 001, 111 respectively.
  - ALUWB then asserts regwrite 1, regdst 1.
  - funct 000111 -> 0,1,6,0 with regwrite never 1.
- beq (op 000100), zero = 1 then zero = 0 on separate runs -> in state 8: alucontrol 110, pcsrc 01, pcen equals zero. Toggling zero within state 8 toggles pcen combinationally.
- sw, addi, j and unknown op 111111:
  - sw -> 0,1,2,5,0 with memwrite only in 5.
  - addi -> 0,1,9,10,0 with alusrcb 10 in 9.
  - j -> 0,1,11,0 with pcsrc 10, pcen 1.
  - Unknown op -> 0,1,0 with no write enables.
